render_frame_scheduler: RTL and testbench
=========================================

// Module: render_frame_scheduler
// PURPOSE
//  Render-domain sequencer for one frame of work. Launches the frame driver and the render manager on display frame ticks.
//  Detects when the frame driver, renderer and depth pipeline have drained, then requests the double framebuffer swap on the next tick.
//  Overrunning frames are dropped, not torn: no swap, and the previous front buffer stays on screen.
//  Sits between the synced VGA frame pulse, frame_driver, render_manager and double_framebuffer.
// PARAMETERS
//  DRAIN_CYCLES  8   consecutive idle cycles required after draw_done before a frame counts as complete (covers depthbuffer latency)
//  MAX_OVERRUN   3   frame ticks tolerated inside one frame before it is aborted; must be >= 1
//  CNT_W         16  width of the frame/overrun/abort counters
// PORTS
//  clk             in   1      render clock
//  rst_n           in   1      asynchronous, active-low reset
//  enable          in   1      scheduler enable
//  frame_tick      in   1      1-cycle pulse per display frame, already synced to clk
//  scene_ready     in   1      scene loaded (create_done, synced); level
//  draw_done       in   1      1-cycle pulse: frame driver has fed its last triangle
//  driver_busy     in   1      frame driver busy
//  renderer_busy   in   1      render manager busy
//  begin_frame     out  1      1-cycle pulse to render manager (clear plus start)
//  draw_start      out  1      1-cycle pulse to frame driver
//  swap            out  1      1-cycle pulse to double_framebuffer
//  abort           out  1      1-cycle pulse: frame abandoned by the watchdog
//  frame_active    out  1      high in LAUNCH, DRAW and DRAIN
//  frame_cnt       out  CNT_W  swaps issued; saturates
//  overrun_cnt     out  CNT_W  ticks received while in DRAW or DRAIN; saturates
//  abort_cnt       out  CNT_W  aborts issued; saturates
//  state_o         out  3      current state encoding, for debug
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; all counters and the drain timer are 0.
//  All outputs are registered. Pulses are exactly 1 cycle long. T = cycle in which frame_tick is sampled high.
//  go = enable & scene_ready.
//  States and transitions:
//   IDLE:       go -> WAIT_FRAME. Ticks are ignored.
//   WAIT_FRAME: !go -> IDLE. Tick -> LAUNCH; begin_frame=1 at T+1.
//   LAUNCH:     single cycle, unconditional -> DRAW; draw_start=1 at T+2.
//   DRAW:       draw_done -> DRAIN. The drain timer clears on entry.
//   DRAIN:      timer counts cycles where !driver_busy & !renderer_busy; any busy cycle clears it.
//               When the timer reaches DRAIN_CYCLES -> READY.
//   READY:      !go -> IDLE; the frame is discarded and no swap occurs.
//               Tick -> LAUNCH with swap=1 and begin_frame=1 both at T+1; frame_cnt++.
//  Overrun: a tick in DRAW or DRAIN increments overrun_cnt and the per-frame tick counter.
//   The per-frame tick counter clears on LAUNCH.
//   When it reaches MAX_OVERRUN: abort=1 next cycle, abort_cnt++, -> WAIT_FRAME; no swap.
//  Simultaneous events:
//   Tick on the same cycle the drain timer completes: treated as a READY tick (swap and launch at T+1); not counted as overrun.
//   draw_done together with a tick in DRAW: both take effect (-> DRAIN, overrun counted).
//   Abort condition and drain completion on the same cycle: completion wins.
//  !go in DRAW or DRAIN: the frame runs to READY, then READY exits to IDLE without swapping.
//  draw_done outside DRAW is ignored.
//  Reset mid-frame: immediately IDLE with outputs 0. No swap is ever emitted from reset.
//  Counters saturate at all-ones. No other arithmetic.
// STRUCTURE
//  render_pkg gains typedef enum logic [2:0] sched_state_t {IDLE, WAIT_FRAME, LAUNCH, DRAW, DRAIN, READY}.
//  Sub-module busy_quiet_timer (params DRAIN_CYCLES; inputs clear, busy; output quiet) holds the drain timer.
//  The FSM, watchdog and counters stay in this module.
// TESTING
//  1. Reset, enable=1, scene_ready=1, tick at cycle 10 -> begin_frame@11, draw_start@12, frame_active=1 from 11.
//  2. draw_done@40, busy low, DRAIN_CYCLES=8, tick@100 -> READY by cycle 49; swap and begin_frame@101; frame_cnt=1.
//  3. draw_done withheld, ticks@10,@20,@30,@40 with MAX_OVERRUN=3 -> launch@11; overrun_cnt=3; abort@41; abort_cnt=1;
//     no swap; next tick relaunches without swap.
//  4. renderer_busy pulses high every 5 cycles after draw_done, DRAIN_CYCLES=8 -> never reaches READY until the pulses stop, then READY after 8 quiet cycles.
//  5. Tick on the exact cycle the drain completes -> swap next cycle; overrun_cnt unchanged.
//  6. scene_ready dropped during DRAW; rst_n asserted mid-DRAIN in a second run -> frame completes, READY->IDLE, no swap;
//     reset forces IDLE with all outputs 0 asynchronously.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types for the render-domain frame scheduler.
package render_pkg;

    // Scheduler states; the encoding is visible on state_o for debug.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        LAUNCH     = 3'd2,
        DRAW       = 3'd3,
        DRAIN      = 3'd4,
        READY      = 3'd5
    } sched_state_t;

    // A frame is "in flight" from launch until the pipeline has drained.
    function automatic logic is_frame_active(input sched_state_t s);
        return (s == LAUNCH) || (s == DRAW) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/busy_quiet_timer.sv
// Counts consecutive non-busy cycles. quiet is asserted combinationally in
// the cycle that supplies the DRAIN_CYCLES-th consecutive quiet cycle, so the
// owner can change state on the same clock edge that completes the window.
module busy_quiet_timer #(
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    output logic quiet
);

    localparam int unsigned   TW   = $clog2(DRAIN_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(DRAIN_CYCLES - 1);
    localparam logic [TW-1:0] FULL = TW'(DRAIN_CYCLES);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: restart on clear or any busy cycle, otherwise count up and hold at full.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || busy) begin
            cnt_d = '0;
        end else if (cnt_q != FULL) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Window completes on this cycle when it is quiet and enough quiet cycles preceded it.
    assign quiet = !clear && !busy && (cnt_q >= LAST);

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/render_frame_scheduler.sv
// Render-domain frame sequencer: launches a frame on a display tick, waits for
// the driver/renderer/depth pipeline to drain, then swaps on the next tick.
// Frames that span too many ticks are aborted without a swap.
module render_frame_scheduler
    import render_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter int unsigned MAX_OVERRUN  = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             frame_tick,
    input  logic             scene_ready,
    input  logic             draw_done,
    input  logic             driver_busy,
    input  logic             renderer_busy,
    output logic             begin_frame,
    output logic             draw_start,
    output logic             swap,
    output logic             abort,
    output logic             frame_active,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic [CNT_W-1:0] abort_cnt,
    output logic [2:0]       state_o
);

    localparam int unsigned      OVR_W    = $clog2(MAX_OVERRUN + 1);
    localparam logic [OVR_W-1:0] OVR_LAST = OVR_W'(MAX_OVERRUN - 1);

    sched_state_t     state_q, state_d;
    logic             begin_frame_q, begin_frame_d;
    logic             draw_start_q, draw_start_d;
    logic             swap_q, swap_d;
    logic             abort_q, abort_d;
    logic             frame_active_q, frame_active_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] overrun_cnt_q, overrun_cnt_d;
    logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;
    logic [OVR_W-1:0] ovr_ticks_q, ovr_ticks_d;

    logic go;
    logic drain_quiet;
    logic start_frame;
    logic swap_now;
    logic overrun_tick;

    assign go = enable & scene_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Drain timer runs only while in DRAIN, so it is already zero on entry.
    busy_quiet_timer #(
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_quiet (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q != DRAIN),
        .busy  (driver_busy | renderer_busy),
        .quiet (drain_quiet)
    );

    // Next-state, registered-output and counter logic.
    always_comb begin
        state_d       = state_q;
        begin_frame_d = 1'b0;
        draw_start_d  = 1'b0;
        swap_d        = 1'b0;
        abort_d       = 1'b0;
        ovr_ticks_d   = ovr_ticks_q;
        start_frame   = 1'b0;
        swap_now      = 1'b0;
        overrun_tick  = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!go) state_d = IDLE;
                else if (frame_tick) start_frame = 1'b1;
            end
            LAUNCH: begin
                state_d      = DRAW;
                draw_start_d = 1'b1;
            end
            DRAW, DRAIN: begin
                if ((state_q == DRAIN) && drain_quiet) begin
                    // Completion beats any watchdog tick arriving on the same cycle.
                    if (frame_tick && go) begin
                        start_frame = 1'b1;
                        swap_now    = 1'b1;
                    end else begin
                        state_d = READY;
                    end
                end else begin
                    if (frame_tick) begin
                        overrun_tick = 1'b1;
                        ovr_ticks_d  = ovr_ticks_q + OVR_W'(1);
                        if (ovr_ticks_q >= OVR_LAST) begin
                            abort_d = 1'b1;
                            state_d = WAIT_FRAME;
                        end
                    end
                    if ((state_q == DRAW) && draw_done && !abort_d) state_d = DRAIN;
                end
            end
            READY: begin
                // Losing go discards the finished frame; the old front buffer stays.
                if (!go) state_d = IDLE;
                else if (frame_tick) begin
                    start_frame = 1'b1;
                    swap_now    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            state_d       = LAUNCH;
            begin_frame_d = 1'b1;
            ovr_ticks_d   = '0;
        end

        swap_d         = swap_now;
        frame_active_d = is_frame_active(state_d);
        frame_cnt_d    = swap_now     ? sat_inc(frame_cnt_q)   : frame_cnt_q;
        overrun_cnt_d  = overrun_tick ? sat_inc(overrun_cnt_q) : overrun_cnt_q;
        abort_cnt_d    = abort_d      ? sat_inc(abort_cnt_q)   : abort_cnt_q;
    end

    // State, output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            begin_frame_q  <= 1'b0;
            draw_start_q   <= 1'b0;
            swap_q         <= 1'b0;
            abort_q        <= 1'b0;
            frame_active_q <= 1'b0;
            frame_cnt_q    <= '0;
            overrun_cnt_q  <= '0;
            abort_cnt_q    <= '0;
            ovr_ticks_q    <= '0;
        end else begin
            state_q        <= state_d;
            begin_frame_q  <= begin_frame_d;
            draw_start_q   <= draw_start_d;
            swap_q         <= swap_d;
            abort_q        <= abort_d;
            frame_active_q <= frame_active_d;
            frame_cnt_q    <= frame_cnt_d;
            overrun_cnt_q  <= overrun_cnt_d;
            abort_cnt_q    <= abort_cnt_d;
            ovr_ticks_q    <= ovr_ticks_d;
        end
    end

    assign begin_frame  = begin_frame_q;
    assign draw_start   = draw_start_q;
    assign swap         = swap_q;
    assign abort        = abort_q;
    assign frame_active = frame_active_q;
    assign frame_cnt    = frame_cnt_q;
    assign overrun_cnt  = overrun_cnt_q;
    assign abort_cnt    = abort_cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Self-checking bench for render_frame_scheduler: directed scenarios plus a
// randomized run compared cycle-by-cycle against a behavioural model.
module tb_render_frame_scheduler;

    localparam int DRAIN_CYCLES = 8;
    localparam int MAX_OVERRUN  = 3;
    localparam int CNT_W        = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_DRAW   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_READY  = 3'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0, frame_tick = 1'b0, scene_ready = 1'b0, draw_done = 1'b0;
    logic driver_busy = 1'b0, renderer_busy = 1'b0;
    logic begin_frame, draw_start, swap, abort, frame_active;
    logic [CNT_W-1:0] frame_cnt, overrun_cnt, abort_cnt;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    render_frame_scheduler #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .MAX_OVERRUN (MAX_OVERRUN),
        .CNT_W       (CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_tick(frame_tick),
        .scene_ready(scene_ready), .draw_done(draw_done), .driver_busy(driver_busy),
        .renderer_busy(renderer_busy), .begin_frame(begin_frame), .draw_start(draw_start),
        .swap(swap), .abort(abort), .frame_active(frame_active), .frame_cnt(frame_cnt),
        .overrun_cnt(overrun_cnt), .abort_cnt(abort_cnt), .state_o(state_o)
    );

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [2:0]  phase;   // which step of the frame we are in (spec numbering)
        logic [7:0]  quiet;   // length of the current run of idle cycles while draining
        logic [7:0]  ticks;   // display ticks seen since this frame was launched
        logic        bf, ds, sw, ab, act;
        logic [15:0] fc, oc, ac;
    } mdl_t;

    mdl_t m = '0;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic mdl_t model_next(input mdl_t c, input logic en, input logic sr,
                                        input logic tk, input logic dd, input logic db,
                                        input logic rb);
        mdl_t n;
        logic gov;
        logic launch;
        logic swp;
        n = c;
        n.bf = 1'b0; n.ds = 1'b0; n.sw = 1'b0; n.ab = 1'b0;
        gov = en & sr;
        launch = 1'b0;
        swp = 1'b0;
        if (c.phase == S_IDLE) begin
            if (gov) n.phase = S_WAIT;
        end else if (c.phase == S_WAIT) begin
            if (!gov) n.phase = S_IDLE;
            else if (tk) launch = 1'b1;
        end else if (c.phase == S_LAUNCH) begin
            n.phase = S_DRAW;
            n.ds = 1'b1;
        end else if (c.phase == S_READY) begin
            if (!gov) n.phase = S_IDLE;
            else if (tk) begin launch = 1'b1; swp = 1'b1; end
        end else begin
            // DRAW or DRAIN
            if (c.phase == S_DRAIN) n.quiet = (!db && !rb) ? c.quiet + 8'd1 : 8'd0;
            if (c.phase == S_DRAIN && int'(n.quiet) >= DRAIN_CYCLES) begin
                if (tk && gov) begin launch = 1'b1; swp = 1'b1; end
                else n.phase = S_READY;
            end else begin
                if (tk) begin
                    n.oc = sat16(c.oc);
                    n.ticks = c.ticks + 8'd1;
                    if (int'(n.ticks) >= MAX_OVERRUN) begin
                        n.ab = 1'b1;
                        n.ac = sat16(c.ac);
                        n.phase = S_WAIT;
                    end
                end
                if (n.phase == S_DRAW && dd) begin
                    n.phase = S_DRAIN;
                    n.quiet = 8'd0;
                end
            end
        end
        if (launch) begin
            n.phase = S_LAUNCH;
            n.bf = 1'b1;
            n.ticks = 8'd0;
        end
        if (swp) begin
            n.sw = 1'b1;
            n.fc = sat16(c.fc);
        end
        n.act = (n.phase == S_LAUNCH) || (n.phase == S_DRAW) || (n.phase == S_DRAIN);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= model_next(m, enable, scene_ready, frame_tick, draw_done, driver_busy, renderer_busy);
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0; scene_ready = 1'b0; frame_tick = 1'b0; draw_done = 1'b0;
        driver_busy = 1'b0; renderer_busy = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [55:0] v;
        do_reset();
        v = {state_o, begin_frame, draw_start, swap, abort, frame_active, frame_cnt, overrun_cnt, abort_cnt};
        checks++;
        if (v !== 56'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", v); end
        // go needs both enable and scene_ready; ticks in IDLE are ignored.
        enable = 1'b1; scene_ready = 1'b0; frame_tick = 1'b1;
        next_cycle();
        checks++;
        if ({state_o, begin_frame} !== {S_IDLE, 1'b0}) begin
            errors++; $display("FAIL idle_no_go: got state=%0d bf=%b want state=0 bf=0", state_o, begin_frame);
        end
        enable = 1'b0; scene_ready = 1'b1;
        next_cycle();
        frame_tick = 1'b0;
        checks++;
        if ({state_o, begin_frame} !== {S_IDLE, 1'b0}) begin
            errors++; $display("FAIL idle_no_enable: got state=%0d bf=%b want state=0 bf=0", state_o, begin_frame);
        end
        $display("test_reset done");
    endtask

    task automatic test_launch();
        logic [5:0] expv;
        do_reset();
        enable = 1'b1; scene_ready = 1'b1;
        repeat (9) next_cycle();
        checks++;
        if (state_o !== S_WAIT) begin errors++; $display("FAIL wait_frame: got %0d want %0d", state_o, S_WAIT); end
        frame_tick = 1'b1;
        next_cycle();
        frame_tick = 1'b0;
        expv = {1'b1, 1'b0, 1'b1, S_LAUNCH};
        checks++;
        if ({begin_frame, draw_start, frame_active, state_o} !== expv) begin
            errors++; $display("FAIL launch_t1: got %b want %b", {begin_frame, draw_start, frame_active, state_o}, expv);
        end
        next_cycle();
        expv = {1'b0, 1'b1, 1'b1, S_DRAW};
        checks++;
        if ({begin_frame, draw_start, frame_active, state_o} !== expv) begin
            errors++; $display("FAIL launch_t2: got %b want %b", {begin_frame, draw_start, frame_active, state_o}, expv);
        end
        next_cycle();
        checks++;
        if (draw_start !== 1'b0) begin errors++; $display("FAIL draw_start_width: got %b want 0", draw_start); end
        $display("test_launch done");
    endtask

    task automatic test_drain_complete();
        repeat (20) next_cycle();
        draw_done = 1'b1;
        next_cycle();
        draw_done = 1'b0;
        checks++;
        if ({state_o, frame_active} !== {S_DRAIN, 1'b1}) begin
            errors++; $display("FAIL enter_drain: got state=%0d act=%b want 4/1", state_o, frame_active);
        end
        repeat (7) next_cycle();
        checks++;
        if (state_o !== S_DRAIN) begin errors++; $display("FAIL drain_7_quiet: got %0d want %0d", state_o, S_DRAIN); end
        next_cycle();
        checks++;
        if ({state_o, frame_active} !== {S_READY, 1'b0}) begin
            errors++; $display("FAIL drain_8_quiet: got state=%0d act=%b want 5/0", state_o, frame_active);
        end
        repeat (30) next_cycle();
        checks++;
        if ({state_o, swap} !== {S_READY, 1'b0}) begin
            errors++; $display("FAIL ready_hold: got state=%0d swap=%b want 5/0", state_o, swap);
        end
        frame_tick = 1'b1;
        next_cycle();
        frame_tick = 1'b0;
        checks++;
        if ({swap, begin_frame, state_o} !== {1'b1, 1'b1, S_LAUNCH}) begin
            errors++; $display("FAIL ready_tick: got swap=%b bf=%b state=%0d want 1/1/2", swap, begin_frame, state_o);
        end
        checks++;
        if ({frame_cnt, overrun_cnt} !== {16'd1, 16'd0}) begin
            errors++; $display("FAIL frame_cnt_1: got fc=%0d oc=%0d want 1/0", frame_cnt, overrun_cnt);
        end
        next_cycle();
        checks++;
        if ({swap, draw_start} !== 2'b01) begin
            errors++; $display("FAIL swap_width: got swap=%b ds=%b want 0/1", swap, draw_start);
        end
        $display("test_drain_complete done");
    endtask

    task automatic test_overrun();
        do_reset();
        enable = 1'b1; scene_ready = 1'b1;
        next_cycle();
        frame_tick = 1'b1;
        next_cycle();
        frame_tick = 1'b0;
        next_cycle();
        for (int k = 1; k <= MAX_OVERRUN; k++) begin
            repeat (9) next_cycle();
            frame_tick = 1'b1;
            next_cycle();
            frame_tick = 1'b0;
            checks++;
            if (overrun_cnt !== 16'(k)) begin
                errors++; $display("FAIL overrun_cnt_%0d: got %0d want %0d", k, overrun_cnt, k);
            end
            checks++;
            if (k < MAX_OVERRUN) begin
                if ({abort, state_o} !== {1'b0, S_DRAW}) begin
                    errors++; $display("FAIL no_abort_%0d: got abort=%b state=%0d want 0/3", k, abort, state_o);
                end
            end else begin
                if ({abort, swap, state_o, abort_cnt} !== {1'b1, 1'b0, S_WAIT, 16'd1}) begin
                    errors++; $display("FAIL abort: got abort=%b swap=%b state=%0d ac=%0d want 1/0/1/1",
                                       abort, swap, state_o, abort_cnt);
                end
            end
        end
        next_cycle();
        checks++;
        if ({abort, state_o} !== {1'b0, S_WAIT}) begin
            errors++; $display("FAIL abort_width: got abort=%b state=%0d want 0/1", abort, state_o);
        end
        repeat (4) next_cycle();
        frame_tick = 1'b1;
        next_cycle();
        frame_tick = 1'b0;
        checks++;
        if ({begin_frame, swap, state_o, frame_cnt} !== {1'b1, 1'b0, S_LAUNCH, 16'd0}) begin
            errors++; $display("FAIL relaunch: got bf=%b swap=%b state=%0d fc=%0d want 1/0/2/0",
                               begin_frame, swap, state_o, frame_cnt);
        end
        next_cycle();
        $display("test_overrun done");
    endtask

    task automatic test_busy_drain();
        int left_drain;
        // draw_done with a tick in DRAW: both take effect, no abort (tick counter was cleared on launch).
        draw_done = 1'b1; frame_tick = 1'b1;
        next_cycle();
        draw_done = 1'b0; frame_tick = 1'b0;
        checks++;
        if ({state_o, abort, overrun_cnt} !== {S_DRAIN, 1'b0, 16'd4}) begin
            errors++; $display("FAIL done_with_tick: got state=%0d abort=%b oc=%0d want 4/0/4", state_o, abort, overrun_cnt);
        end
        left_drain = 0;
        for (int i = 0; i < 40; i++) begin
            renderer_busy = (i % 5 == 0);
            next_cycle();
            if (state_o !== S_DRAIN) left_drain++;
        end
        renderer_busy = 1'b0;
        checks++;
        if (left_drain !== 0) begin errors++; $display("FAIL busy_pulses: got %0d non-drain cycles want 0", left_drain); end
        repeat (3) next_cycle();
        checks++;
        if (state_o !== S_DRAIN) begin errors++; $display("FAIL busy_7_quiet: got %0d want %0d", state_o, S_DRAIN); end
        next_cycle();
        checks++;
        if (state_o !== S_READY) begin errors++; $display("FAIL busy_8_quiet: got %0d want %0d", state_o, S_READY); end
        $display("test_busy_drain done");
    endtask

    task automatic test_tick_on_completion();
        logic [15:0] oc_before;
        frame_tick = 1'b1;
        next_cycle();
        frame_tick = 1'b0;
        checks++;
        if ({swap, state_o, frame_cnt} !== {1'b1, S_LAUNCH, 16'd1}) begin
            errors++; $display("FAIL swap_again: got swap=%b state=%0d fc=%0d want 1/2/1", swap, state_o, frame_cnt);
        end
        next_cycle();
        draw_done = 1'b1;
        next_cycle();
        draw_done = 1'b0;
        oc_before = overrun_cnt;
        repeat (7) next_cycle();
        frame_tick = 1'b1;
        next_cycle();
        frame_tick = 1'b0;
        checks++;
        if ({swap, begin_frame, abort, state_o} !== {1'b1, 1'b1, 1'b0, S_LAUNCH}) begin
            errors++; $display("FAIL tick_at_completion: got swap=%b bf=%b abort=%b state=%0d want 1/1/0/2",
                               swap, begin_frame, abort, state_o);
        end
        checks++;
        if ({overrun_cnt, frame_cnt} !== {oc_before, 16'd2}) begin
            errors++; $display("FAIL tick_at_completion_cnt: got oc=%0d fc=%0d want %0d/2", overrun_cnt, frame_cnt, oc_before);
        end
        next_cycle();
        $display("test_tick_on_completion done");
    endtask

    task automatic test_scene_drop();
        logic swap_seen;
        logic [55:0] v;
        swap_seen = 1'b0;
        scene_ready = 1'b0;
        repeat (3) next_cycle();
        checks++;
        if ({state_o, frame_active} !== {S_DRAW, 1'b1}) begin
            errors++; $display("FAIL drop_keeps_draw: got state=%0d act=%b want 3/1", state_o, frame_active);
        end
        draw_done = 1'b1;
        next_cycle();
        draw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            swap_seen |= swap;
        end
        checks++;
        if (state_o !== S_READY) begin errors++; $display("FAIL drop_ready: got %0d want %0d", state_o, S_READY); end
        next_cycle();
        swap_seen |= swap;
        checks++;
        if ({state_o, swap_seen, frame_cnt} !== {S_IDLE, 1'b0, 16'd2}) begin
            errors++; $display("FAIL drop_idle: got state=%0d swap_seen=%b fc=%0d want 0/0/2", state_o, swap_seen, frame_cnt);
        end
        // Second run: reset lands in the middle of DRAIN.
        scene_ready = 1'b1;
        next_cycle();
        frame_tick = 1'b1;
        next_cycle();
        frame_tick = 1'b0;
        next_cycle();
        draw_done = 1'b1;
        next_cycle();
        draw_done = 1'b0;
        repeat (3) next_cycle();
        checks++;
        if (state_o !== S_DRAIN) begin errors++; $display("FAIL pre_reset_drain: got %0d want %0d", state_o, S_DRAIN); end
        rst_n = 1'b0;
        #1;
        v = {state_o, begin_frame, draw_start, swap, abort, frame_active, frame_cnt, overrun_cnt, abort_cnt};
        checks++;
        if (v !== 56'd0) begin errors++; $display("FAIL async_reset: got %h want 0", v); end
        next_cycle();
        checks++;
        if ({state_o, swap} !== {S_IDLE, 1'b0}) begin
            errors++; $display("FAIL reset_hold: got state=%0d swap=%b want 0/0", state_o, swap);
        end
        rst_n = 1'b1;
        $display("test_scene_drop done");
    endtask

    task automatic test_random();
        logic [55:0] act_v, exp_v;
        int bad;
        int swaps, aborts;
        bad = 0; swaps = 0; aborts = 0;
        do_reset();
        enable = 1'b1; scene_ready = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rst_n         = ($urandom_range(0, 1499) != 0);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 199) == 0) scene_ready = ~scene_ready;
            frame_tick    = ($urandom_range(0, 24) == 0);
            draw_done     = ($urandom_range(0, 19) == 0);
            driver_busy   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) renderer_busy = ~renderer_busy;
            next_cycle();
            act_v = {state_o, begin_frame, draw_start, swap, abort, frame_active, frame_cnt, overrun_cnt, abort_cnt};
            exp_v = {m.phase, m.bf, m.ds, m.sw, m.ab, m.act, m.fc, m.oc, m.ac};
            if (swap === 1'b1) swaps++;
            if (abort === 1'b1) aborts++;
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                bad++;
                if (bad <= 10) $display("FAIL random_cycle_%0d: got %h want %h", c, act_v, exp_v);
            end
        end
        frame_tick = 1'b0; draw_done = 1'b0; rst_n = 1'b1;
        $display("test_random done: swaps=%0d aborts=%0d", swaps, aborts);
    endtask

    initial begin
        test_reset();
        test_launch();
        test_drain_complete();
        test_overrun();
        test_busy_drain();
        test_tick_on_completion();
        test_scene_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
